// File: rtl/game_ctrl.sv
// Dinosaur runner sequencer: IDLE/RUN/OVER FSM, score and scroll-speed ramp.
// Optional GAME_CTRL_HISCORE_EN adds a clrn-only high score and a new-record flag.
module game_ctrl #(
    parameter int FRAMES_PER_POINT   = 6,
    parameter int POINTS_PER_SPEEDUP = 100,
    parameter int SPEED_INIT         = 1,
    parameter int SPEED_MAX          = 12,
    parameter int OVER_HOLD_FRAMES   = 30,
    parameter int SCORE_MAX          = 9999
) (
    input  logic        CLK,
    input  logic        clrn,
    input  logic        tick_frame,
    input  logic        btn_jump,
    input  logic        collision,
    output logic        game_status,
    output logic        game_over,
    output logic [3:0]  speed,
    output logic [13:0] score,
    output logic        restart_ok
`ifdef GAME_CTRL_HISCORE_EN
   ,output logic [13:0] hiscore,
    output logic        new_record
`endif
);

    localparam int FW = (FRAMES_PER_POINT > 1) ? $clog2(FRAMES_PER_POINT) : 1;
    localparam int PW = (POINTS_PER_SPEEDUP > 1) ? $clog2(POINTS_PER_SPEEDUP) : 1;
    localparam int HW = (OVER_HOLD_FRAMES > 0) ? $clog2(OVER_HOLD_FRAMES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          btn_d;
    logic          hit;
    logic [FW-1:0] frame_cnt;
    logic [PW-1:0] point_cnt;
    logic [HW-1:0] hold_cnt;
    logic          press;
    logic          start;
    logic          fin;

    assign press = btn_jump & ~btn_d;

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        fin      = 1'b0;
        unique case (state)
            IDLE: begin
                if (press) begin
                    state_nx = RUN;
                    start    = 1'b1;
                end
            end
            RUN: begin
                if (tick_frame && (hit || collision)) begin
                    state_nx = OVER;
                    fin      = 1'b1;
                end
            end
            OVER: begin
                // presses during the hold window are dropped, not queued
                if (press && hold_cnt == '0) begin
                    state_nx = RUN;
                    start    = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge clrn) begin
        if (!clrn) begin
            state     <= IDLE;
            btn_d     <= 1'b0;
            hit       <= 1'b0;
            frame_cnt <= '0;
            point_cnt <= '0;
            hold_cnt  <= '0;
            score     <= '0;
            speed     <= 4'(SPEED_INIT);
        end else begin
            state <= state_nx;
            btn_d <= btn_jump;
            if (start) begin
                score     <= '0;
                speed     <= 4'(SPEED_INIT);
                frame_cnt <= '0;
                point_cnt <= '0;
                hit       <= 1'b0;
            end else if (state == RUN) begin
                hit <= hit | collision;
                if (fin) begin
                    hold_cnt <= HW'(OVER_HOLD_FRAMES);
                end else if (tick_frame) begin
                    if (frame_cnt == FW'(FRAMES_PER_POINT - 1)) begin
                        frame_cnt <= '0;
                        if (score < 14'(SCORE_MAX))
                            score <= score + 14'd1;
                        if (point_cnt == PW'(POINTS_PER_SPEEDUP - 1)) begin
                            point_cnt <= '0;
                            if (speed < 4'(SPEED_MAX))
                                speed <= speed + 4'd1;
                        end else begin
                            point_cnt <= point_cnt + PW'(1);
                        end
                    end else begin
                        frame_cnt <= frame_cnt + FW'(1);
                    end
                end
            end else if (state == OVER && tick_frame && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
            end
        end
    end

    assign game_status = (state == RUN);
    assign game_over   = (state == OVER);
    assign restart_ok  = (state == IDLE) || (state == OVER && hold_cnt == '0);

`ifdef GAME_CTRL_HISCORE_EN
    logic rec;

    always_ff @(posedge CLK or negedge clrn) begin
        if (!clrn) begin
            hiscore <= '0;
            rec     <= 1'b0;
        end else if (fin) begin
            rec <= (score > hiscore);
            if (score > hiscore)
                hiscore <= score;
        end else if (start) begin
            rec <= 1'b0;
        end
    end

    assign new_record = rec && (state == OVER);
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: default instance plus a fast-saturating one
// (FRAMES_PER_POINT=1, POINTS_PER_SPEEDUP=1, SCORE_MAX=20) sharing inputs.
module tb_game_ctrl;

    logic        CLK = 1'b0;
    logic        clrn;
    logic        tick_frame;
    logic        btn_jump;
    logic        collision;
    logic        game_status,  game_over,  restart_ok;
    logic [3:0]  speed;
    logic [13:0] score;
    logic        game_status2, game_over2, restart_ok2;
    logic [3:0]  speed2;
    logic [13:0] score2;
`ifdef GAME_CTRL_HISCORE_EN
    logic [13:0] hiscore, hiscore2;
    logic        new_record, new_record2;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    game_ctrl dut (
        .CLK        (CLK),
        .clrn       (clrn),
        .tick_frame (tick_frame),
        .btn_jump   (btn_jump),
        .collision  (collision),
        .game_status(game_status),
        .game_over  (game_over),
        .speed      (speed),
        .score      (score),
        .restart_ok (restart_ok)
`ifdef GAME_CTRL_HISCORE_EN
       ,.hiscore    (hiscore),
        .new_record (new_record)
`endif
    );

    game_ctrl #(
        .FRAMES_PER_POINT  (1),
        .POINTS_PER_SPEEDUP(1),
        .SCORE_MAX         (20)
    ) dut2 (
        .CLK        (CLK),
        .clrn       (clrn),
        .tick_frame (tick_frame),
        .btn_jump   (btn_jump),
        .collision  (collision),
        .game_status(game_status2),
        .game_over  (game_over2),
        .speed      (speed2),
        .score      (score2),
        .restart_ok (restart_ok2)
`ifdef GAME_CTRL_HISCORE_EN
       ,.hiscore    (hiscore2),
        .new_record (new_record2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK) tick_frame = 1'b1;
            @(negedge CLK) tick_frame = 1'b0;
        end
    endtask

    task automatic press();
        @(negedge CLK) btn_jump = 1'b1;
        @(negedge CLK) btn_jump = 1'b0;
    endtask

    task automatic coll_pulse();
        @(negedge CLK) collision = 1'b1;
        @(negedge CLK) collision = 1'b0;
    endtask

    task automatic tick_coll();
        @(negedge CLK) begin tick_frame = 1'b1; collision = 1'b1; end
        @(negedge CLK) begin tick_frame = 1'b0; collision = 1'b0; end
    endtask

    initial begin
        clrn       = 1'b0;
        tick_frame = 1'b0;
        btn_jump   = 1'b0;
        collision  = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_status",  game_status, 0);
        chk("rst_over",    game_over,   0);
        chk("rst_speed",   speed,       1);
        chk("rst_score",   score,       0);
        chk("rst_rok",     restart_ok,  1);
        clrn = 1'b1;

        tick(10);
        chk("idle_status", game_status, 0);
        chk("idle_score",  score,       0);
        chk("idle_speed",  speed,       1);
        chk("idle_rok",    restart_ok,  1);

        // hold the button through the whole run
        @(negedge CLK) btn_jump = 1'b1;
        @(negedge CLK);
        chk("start_lat",   game_status, 1);
        chk("run_rok",     restart_ok,  0);
        tick(6);
        chk("score_6tk",   score,       1);
        tick(593);
        chk("score_599",   score,       99);
        chk("speed_599",   speed,       1);
        tick(1);
        chk("score_600",   score,       100);
        chk("speed_600",   speed,       2);
        chk("held_run",    game_status, 1);
        btn_jump = 1'b0;

        tick(3);
        coll_pulse();
        chk("hit_wait",    game_status, 1);
        tick(1);
        chk("hit_over",    game_over,   1);
        chk("hit_stat",    game_status, 0);
        chk("hit_score",   score,       100);
        chk("hit_speed",   speed,       2);
        chk("hold_rok0",   restart_ok,  0);
`ifdef GAME_CTRL_HISCORE_EN
        chk("hi_first",    hiscore,     100);
        chk("rec_first",   new_record,  1);
`endif

        tick(5);
        press();
        chk("lock_over",   game_over,   1);
        tick(24);
        chk("lock_29",     restart_ok,  0);
        tick(1);
        chk("lock_30",     restart_ok,  1);
        chk("over_score",  score,       100);
        press();
        chk("rs_status",   game_status, 1);
        chk("rs_score",    score,       0);
        chk("rs_speed",    speed,       1);

        tick(222);
        chk("run37",       score,       37);
        tick(2);
        coll_pulse();
        tick(1);
        chk("p37_over",    game_over,   1);
        chk("p37_score",   score,       37);
        chk("p37_speed",   speed,       1);
`ifdef GAME_CTRL_HISCORE_EN
        chk("hi_keep",     hiscore,     100);
        chk("rec_none",    new_record,  0);
`endif

        tick(30);
        press();
        tick(299);
        chk("pre50",       score,       49);
        tick_coll();
        chk("sim_over",    game_over,   1);
        chk("sim_score",   score,       49);

        @(negedge CLK) clrn = 1'b0;
        @(negedge CLK) clrn = 1'b1;
        chk("r2_score",    score2,      0);
        chk("r2_speed",    speed2,      1);
        press();
        chk("r2_start",    game_status2, 1);
        tick(40);
        chk("sat_score",   score2,      20);
        chk("sat_speed",   speed2,      12);
        chk("dflt_40",     score,       6);

        @(negedge CLK) clrn = 1'b0;
        #1;
        chk("mid_status",  game_status2, 0);
        chk("mid_over",    game_over2,   0);
        chk("mid_score",   score2,       0);
        chk("mid_speed",   speed2,       1);
        chk("mid_rok",     restart_ok2,  1);
        @(negedge CLK) clrn = 1'b1;

`ifdef GAME_CTRL_HISCORE_EN
        press();
        tick(25);
        tick_coll();
        chk("hi2_over",    game_over2,  1);
        chk("hi2_val",     hiscore2,    20);
        chk("hi2_rec",     new_record2, 1);
        chk("hi1_val",     hiscore,     4);
        @(negedge CLK) clrn = 1'b0;
        #1;
        chk("hi2_clr",     hiscore2,    0);
        @(negedge CLK) clrn = 1'b1;
`endif

        repeat (2) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
